kcpsm3_pc_sequencer: RTL
========================

Name: kcpsm3_pc_sequencer

Overview:
Program-flow controller for the pipelined KCPSM3 core: owns the program counter, the call/return stack, the interrupt-enable state and the interrupt shadow flags. Each executed instruction is presented once with a step strobe. The block resolves JUMP, CALL, RETURN, RETURNI and ENABLE/DISABLE INTERRUPT against the current Z/C flags, and pre-empts instructions with interrupts. Sits between the instruction-fetch stage, which consumes pc_o, and the ALU flag register, which consumes the restore outputs.

Parameters:
CODE_DEPTH, 10, PC and stack entry width in bits.
STACK_DEPTH, 5, log2 of stack entries (32 entries).
RESET_VECTOR, 0, PC value after reset.
INTERRUPT_VECTOR, 1023, PC loaded when an interrupt is taken.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
step_i  in  1  instr_i is the instruction at pc_o; resolve it this cycle.
instr_i  in  18  instruction word; fields per kcpsm3_inc instr_t.
zero_i  in  1  current Z flag.
carry_i  in  1  current C flag.
irq_i  in  1  level-sensitive interrupt request.
pc_o  out  CODE_DEPTH  address of the next instruction to execute.
ie_o  out  1  interrupt enable.
int_ack_o  out  1  one-cycle pulse: interrupt taken.
flag_restore_o  out  1  one-cycle pulse: load Z/C from the two outputs below.
zero_restore_o  out  1  shadow Z, valid with flag_restore_o.
carry_restore_o  out  1  shadow C, valid with flag_restore_o.
depth_o  out  STACK_DEPTH+1  occupied stack entries, 0..32.
stack_ovf_o  out  1  sticky: push with depth 32.
stack_unf_o  out  1  sticky: pop with depth 0.
illegal_op_o  out  1  one-cycle pulse: unused opcode stepped.

Behaviour:
- Reset: pc_o=RESET_VECTOR; ie_o, int_ack_o, flag_restore_o, zero/carry_restore_o, stack_ovf_o, stack_unf_o, illegal_op_o = 0; depth_o=0; stack pointer=0. Stack RAM contents are not cleared. Reset wins over step_i in the same cycle.
- step_i=0: all state holds; pulse outputs are 0.
- All effects are registered, so new pc_o is visible the cycle after step_i.
- Condition: if op_cond_sel=0, the branch is taken. Otherwise select on jump.flags: Z -> zero_i, NZ -> !zero_i, C -> carry_i, NC -> !carry_i.
- Interrupt (step_i & irq_i & ie_o): the current instruction is NOT executed.
  - push pc_o; pc<=INTERRUPT_VECTOR; ie<=0.
  - shadow Z/C <= zero_i/carry_i.
  - int_ack_o=1 the next cycle.
  - Interrupt has priority over every opcode, including CALL, RETURN and RETURNI.
- JUMP taken: pc<=code_addr. Not taken: pc<=pc+1.
- CALL taken: push pc+1; pc<=code_addr. Not taken: pc+1.
- RETURN taken: pc<=pop. Not taken: pc+1.
- RETURNI: pc<=pop (unconditional); ie<=instr[0]; flag_restore_o=1 next cycle with the shadow Z/C.
- INTERRUPT opcode: ie<=instr[0]; pc+1.
- Opcodes 01,04,08,0b,11,12,13,14,19,1b,1d,1f: pc+1; illegal_op_o pulse.
- All other opcodes: pc+1.
- PC arithmetic is modulo 2^CODE_DEPTH; 1023+1 wraps to 0.
- Stack is a circular buffer: push writes [sp] then sp+1; pop reads [sp-1] then sp-1. sp is modulo 32.
- Push at depth 32: the oldest entry is overwritten, depth stays 32, stack_ovf_o is set.
- Pop at depth 0: returns stale data at sp-1, sp wraps, depth stays 0, stack_unf_o is set.
- Sticky error flags clear only on rst.
- irq_i with ie_o=0 is ignored, not latched. Interrupt and RETURNI never occur in the same cycle, because interrupt wins.

Test Plan:
- Reset then step LOADs at 0,1,2 -> pc_o 1,2,3; ie_o=0; depth_o=0.
- Z=1: JUMP Z 0x120 -> pc 0x120. Z=0: JUMP Z 0x120 from pc 5 -> pc 6. C=0: CALL NC 0x200 from pc 7 -> pc 0x200, depth 1; then RETURN -> pc 8, depth 0.
- ENABLE INTERRUPT at pc 10; irq_i=1 with CALL at pc 11, Z=1, C=0 -> pc 0x3FF, int_ack_o one-cycle pulse, ie 0, depth 1. Then RETURNI ENABLE -> pc 11, flag_restore_o pulse with Z=1/C=0, ie 1.
- 33 nested unconditional CALLs -> depth_o 32, stack_ovf_o=1; 32 RETURNs unwind to the newest 32 return addresses in order.
- RETURN at depth 0 -> stack_unf_o=1, depth stays 0. Step opcode 0x19 -> illegal_op_o pulse, pc+1. JUMP from 0x3FF not taken -> pc 0.
- rst asserted mid-sequence at depth 3 with ie=1 -> next cycle pc 0, depth 0, ie 0, sticky flags 0.

Source files
------------

// File: rtl/kcpsm3_pc_sequencer.sv
// KCPSM3 program-flow controller: program counter, circular call/return stack,
// interrupt enable and Z/C shadow flags, advanced once per stepped instruction.
module kcpsm3_pc_sequencer #(
    parameter int unsigned CODE_DEPTH       = 10,
    parameter int unsigned STACK_DEPTH      = 5,
    parameter int unsigned RESET_VECTOR     = 0,
    parameter int unsigned INTERRUPT_VECTOR = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_i,
    input  logic [17:0]            instr_i,
    input  logic                   zero_i,
    input  logic                   carry_i,
    input  logic                   irq_i,
    output logic [CODE_DEPTH-1:0]  pc_o,
    output logic                   ie_o,
    output logic                   int_ack_o,
    output logic                   flag_restore_o,
    output logic                   zero_restore_o,
    output logic                   carry_restore_o,
    output logic [STACK_DEPTH:0]   depth_o,
    output logic                   stack_ovf_o,
    output logic                   stack_unf_o,
    output logic                   illegal_op_o
);

    localparam int unsigned ENTRIES = 1 << STACK_DEPTH;
    localparam logic [STACK_DEPTH:0]  DEPTH_FULL = (STACK_DEPTH + 1)'(ENTRIES);
    localparam logic [CODE_DEPTH-1:0] PC_RESET   = CODE_DEPTH'(RESET_VECTOR);
    localparam logic [CODE_DEPTH-1:0] PC_IRQ     = CODE_DEPTH'(INTERRUPT_VECTOR);

    typedef enum logic [4:0] {
        OP_RETURN    = 5'h15,
        OP_CALL      = 5'h18,
        OP_JUMP      = 5'h1A,
        OP_RETURNI   = 5'h1C,
        OP_INTERRUPT = 5'h1E
    } flow_op_e;

    typedef enum logic [1:0] {
        FL_Z  = 2'b00,
        FL_NZ = 2'b01,
        FL_C  = 2'b10,
        FL_NC = 2'b11
    } cond_e;

    logic [4:0]            op;
    logic                  cond_sel;
    logic [1:0]            cond_flags;
    logic [CODE_DEPTH-1:0] code_addr;
    logic                  taken;

    logic [CODE_DEPTH-1:0]  pc_q, pc_d, pc_inc;
    logic                   ie_q, ie_d;
    logic                   shz_q, shz_d, shc_q, shc_d;
    logic                   ack_q, ack_d;
    logic                   fr_q, fr_d;
    logic                   ill_q, ill_d;
    logic [STACK_DEPTH-1:0] sp_q, sp_d, sp_m1;
    logic [STACK_DEPTH:0]   depth_q, depth_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;

    logic                   push, pop;
    logic [CODE_DEPTH-1:0]  push_data, pop_data;
    logic [CODE_DEPTH-1:0]  stack_mem [ENTRIES];

    assign op         = instr_i[17:13];
    assign cond_sel   = instr_i[12];
    assign cond_flags = instr_i[11:10];
    assign code_addr  = instr_i[CODE_DEPTH-1:0];
    assign pc_inc     = pc_q + CODE_DEPTH'(1);
    assign sp_m1      = sp_q - STACK_DEPTH'(1);
    assign pop_data   = stack_mem[sp_m1];

    always_comb begin
        taken = 1'b1;
        if (cond_sel) begin
            unique case (cond_flags)
                FL_Z:    taken = zero_i;
                FL_NZ:   taken = !zero_i;
                FL_C:    taken = carry_i;
                FL_NC:   taken = !carry_i;
                default: taken = 1'b1;
            endcase
        end
    end

    always_comb begin
        pc_d      = pc_q;
        ie_d      = ie_q;
        shz_d     = shz_q;
        shc_d     = shc_q;
        ack_d     = 1'b0;
        fr_d      = 1'b0;
        ill_d     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_inc;
        if (step_i) begin
            if (irq_i && ie_q) begin
                // The pre-empted instruction is re-fetched on return, so push pc_q itself.
                push      = 1'b1;
                push_data = pc_q;
                pc_d      = PC_IRQ;
                ie_d      = 1'b0;
                shz_d     = zero_i;
                shc_d     = carry_i;
                ack_d     = 1'b1;
            end else begin
                pc_d = pc_inc;
                case (op)
                    OP_JUMP: begin
                        if (taken) pc_d = code_addr;
                    end
                    OP_CALL: begin
                        if (taken) begin
                            push = 1'b1;
                            pc_d = code_addr;
                        end
                    end
                    OP_RETURN: begin
                        if (taken) begin
                            pop  = 1'b1;
                            pc_d = pop_data;
                        end
                    end
                    OP_RETURNI: begin
                        pop  = 1'b1;
                        pc_d = pop_data;
                        ie_d = instr_i[0];
                        fr_d = 1'b1;
                    end
                    OP_INTERRUPT: ie_d = instr_i[0];
                    5'h01, 5'h04, 5'h08, 5'h0B, 5'h11, 5'h12,
                    5'h13, 5'h14, 5'h19, 5'h1B, 5'h1D, 5'h1F: ill_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Depth saturates at both ends while sp keeps wrapping, so a full stack
    // overwrites its oldest entry and an empty pop returns stale data.
    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push) begin
            sp_d = sp_q + STACK_DEPTH'(1);
            if (depth_q == DEPTH_FULL) ovf_d = 1'b1;
            else                       depth_d = depth_q + (STACK_DEPTH + 1)'(1);
        end else if (pop) begin
            sp_d = sp_m1;
            if (depth_q == '0) unf_d = 1'b1;
            else               depth_d = depth_q - (STACK_DEPTH + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= PC_RESET;
            ie_q    <= 1'b0;
            shz_q   <= 1'b0;
            shc_q   <= 1'b0;
            ack_q   <= 1'b0;
            fr_q    <= 1'b0;
            ill_q   <= 1'b0;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ie_q    <= ie_d;
            shz_q   <= shz_d;
            shc_q   <= shc_d;
            ack_q   <= ack_d;
            fr_q    <= fr_d;
            ill_q   <= ill_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) stack_mem[sp_q] <= push_data;
    end

    assign pc_o            = pc_q;
    assign ie_o            = ie_q;
    assign int_ack_o       = ack_q;
    assign flag_restore_o  = fr_q;
    assign zero_restore_o  = shz_q;
    assign carry_restore_o = shc_q;
    assign depth_o         = depth_q;
    assign stack_ovf_o     = ovf_q;
    assign stack_unf_o     = unf_q;
    assign illegal_op_o    = ill_q;

endmodule
